// File: rtl/sisc_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame constants.
package sisc_pkg;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_asm.sv
// Byte-to-word assembler: shifts bytes in MSB first and presents each completed
// big-endian word with a one-cycle word_valid pulse in the cycle after its 4th byte.
module word_asm
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shreg    <= {shreg[15:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
        // The held word only changes on completion, so it stays stable for the write.
        if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {shreg, byte_data};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes big-endian words into instruction memory
// and releases the processor reset once the image is complete. Optional: LOADER_CSUM_EN.
module prog_loader
  import sisc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [15:0] im_waddr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_f,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready is
  // registered from the next state and never looks at rx_valid.

`ifdef LOADER_CSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state, state_nxt;
  logic        xfer;
  logic        last_byte;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [15:0] hdr;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic        word_valid;
  logic [31:0] word;
`ifdef LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer      = rx_valid && rx_ready;
  assign hdr       = {n_hi, rx_data};
  assign last_byte = xfer && (state == S_DATA) && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign dbg_state = state;

  word_asm u_word_asm (
    .clk        (clk),
    .rst_f      (rst_f),
    .byte_valid (xfer && (state == S_DATA)),
    .byte_data  (rx_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

  assign im_we    = word_valid;
  assign im_wdata = word;

  always_ff @(posedge clk) begin
    if (!rst_f) state <= S_CNT_HI;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CNT_HI: if (xfer) state_nxt = S_CNT_LO;
      S_CNT_LO: begin
        if (xfer) begin
          if (hdr > MAX_WORDS)  state_nxt = S_ERR;
          else if (hdr == '0)   state_nxt = END_STATE;
          else                  state_nxt = S_DATA;
        end
      end
      S_DATA: if (last_byte && (word_cnt == n_words - 16'd1)) state_nxt = END_STATE;
`ifdef LOADER_CSUM_EN
      S_CSUM: if (xfer) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
`else
      S_CSUM: state_nxt = S_ERR;
`endif
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      rx_ready  <= 1'b0;
      im_waddr  <= BASE_ADDR;
      cpu_rst_f <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      n_hi      <= '0;
      n_words   <= '0;
    end else begin
      rx_ready  <= (state_nxt != S_DONE) && (state_nxt != S_ERR);
      // Terminal flags follow the state a cycle later, so the last write precedes release.
      done      <= (state == S_DONE);
      cpu_rst_f <= (state == S_DONE);
      err       <= (state == S_ERR);
      if (xfer && (state == S_CNT_HI)) n_hi    <= rx_data;
      if (xfer && (state == S_CNT_LO)) n_words <= hdr;
      if (last_byte) begin
        im_waddr <= BASE_ADDR + word_cnt;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_f)                         csum <= '0;
    else if (xfer && (state != S_CSUM)) csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks of prog_loader against a frame-level reference model.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        im_we;
  logic [15:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst_f;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  localparam logic [15:0] BASE = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_xfer_cyc = 0;

  logic [47:0] exp_q[$];
  int          exp_cyc[$];
  logic [47:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] words[$];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(16'd1024)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .cpu_rst_f (cpu_rst_f),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // write monitor
  always @(negedge clk) begin
    if (im_we) begin
      got_q.push_back({im_waddr, im_wdata});
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int g);
    int waited;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      check("xfer_timeout", 0, 1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_xfer_cyc = cyc;
  endtask

  task automatic do_reset(input int low_cycles, input string tag);
    @(negedge clk);
    rst_f    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (low_cycles) @(negedge clk);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_im_we"}, im_we, 0);
    check({tag, "_waddr"}, im_waddr, BASE);
    check({tag, "_wdata"}, im_wdata, 0);
    check({tag, "_cpu_rst_f"}, cpu_rst_f, 0);
    check({tag, "_done_err"}, {done, err}, 0);
    rst_f    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rx_ready_after"}, rx_ready, 1);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_write"}, got_q[i], exp_q[i]);
      check({tag, "_write_cyc"}, got_cyc[i], exp_cyc[i]);
    end
  endtask

  // Sends count header, words[] and (if enabled) the checksum, then checks the end state.
  task automatic run_frame(input string tag, input int maxgap, input bit bad_csum);
    logic [7:0] b;
    logic [7:0] x;
    logic [15:0] n16;
    int n;
    bit seen;
    bit exp_err;
    n = words.size();
    n16 = 16'(n);
    exp_q.delete(); exp_cyc.delete(); got_q.delete(); got_cyc.delete();
    exp_err = 1'b0;
    x = '0;
    b = n16[15:8]; send_byte(b, gap(maxgap)); x ^= b;
    b = n16[7:0];  send_byte(b, gap(maxgap)); x ^= b;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][31 - 8*k -: 8];
        send_byte(b, gap(maxgap));
        x ^= b;
        if (k == 3) begin
          exp_q.push_back({BASE + 16'(i), words[i]});
          exp_cyc.push_back(last_xfer_cyc);
        end
      end
    end
`ifdef LOADER_CSUM_EN
    exp_err = bad_csum;
    b = bad_csum ? (x ^ 8'h01) : x;
    send_byte(b, gap(maxgap));
`endif
    @(negedge clk);
    rx_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done || err) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_end_seen"}, seen, 1);
    check({tag, "_end_cyc"}, cyc, last_xfer_cyc + 1);
    check({tag, "_done"}, done, !exp_err);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cpu_rst_f"}, cpu_rst_f, !exp_err);
    repeat (2) @(negedge clk);
    check({tag, "_rx_ready_term"}, rx_ready, 0);
    check_writes(tag);
  endtask

  initial begin
    do_reset(3, "rst");

    // Directed two-word frame, no gaps.
    words = '{32'h12345678, 32'h9ABCDEF0};
    run_frame("frame2", 0, 1'b0);

    // Same frame with random idle gaps.
    do_reset(2, "rst2");
    run_frame("frame2_gaps", 5, 1'b0);

    // Random frames.
    for (int t = 0; t < 3; t++) begin
      do_reset(1, "rst_r");
      words.delete();
      repeat ($urandom_range(1, 6)) words.push_back($urandom);
      run_frame("rand", 3, 1'b0);
    end

    // Zero-length image.
    do_reset(1, "rst_z");
    words.delete();
    run_frame("zero", 0, 1'b0);

    // Oversize header: rejected right after CNT_LO.
    do_reset(1, "rst_big");
    got_q.delete();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("big_err", err, 1);
    check("big_cpu_rst_f", cpu_rst_f, 0);
    check("big_rx_ready", rx_ready, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    check("big_still_err", {err, done, rx_ready}, 3'b100);
    check("big_nwrites", got_q.size(), 0);

    // Header exactly at the limit is accepted.
    do_reset(1, "rst_max");
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("max_no_err", {err, rx_ready}, 2'b01);

    // Abort after 6 data bytes; only the completed first word was written.
    do_reset(1, "rst_ab");
    got_q.delete(); got_cyc.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_nwrites", got_q.size(), 1);
    if (got_q.size() > 0) check("abort_write", got_q[0], {BASE, 32'h10111213});
    do_reset(1, "rst_ab2");
    repeat (3) @(negedge clk);
    check("abort_no_stale", got_q.size(), 1);
    words = '{32'hAABBCCDD};
    run_frame("after_abort", 0, 1'b0);

`ifdef LOADER_CSUM_EN
    do_reset(1, "rst_cs");
    words = '{32'h11223344};
    run_frame("csum_ok", 0, 1'b0);
    do_reset(1, "rst_cs2");
    run_frame("csum_bad", 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
